uart_baud_gen: RTL and testbench
================================

// Module: uart_baud_gen
// PURPOSE
//  Runtime-programmable UART baud tick generator with fractional divide and N-x oversampling.
//  Produces one oversample tick stream, a tx bit tick locked to it, and a re-phasable rx mid-bit strobe.
//  Sits between the system clock and the uart tx/rx engines; divisor is reloadable without reset.
// PARAMETERS
//  DIV_WIDTH   16   width of integer divisor (clk cycles per oversample tick)
//  FRAC_WIDTH  4    width of fractional divisor, units of 1/2^FRAC_WIDTH cycle
//  OVERSAMPLE  16   oversample ticks per bit; power of 2, >=4
//  RESET_DIV   325  integer divisor after reset (50 MHz, 9600 bps, x16)
//  RESET_FRAC  8    fractional divisor after reset (0.5 cycle)
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous reset, active high
//  en         in   1            count enable; low = freeze all counters
//  div_int    in   DIV_WIDTH    new integer divisor, sampled on div_load
//  div_frac   in   FRAC_WIDTH   new fractional divisor, sampled on div_load
//  div_load   in   1            1-cycle pulse: latch divisor, restart all phases
//  rx_resync  in   1            1-cycle pulse: restart rx bit phase (start-bit edge seen)
//  rx_tick    out  1            1-cycle oversample tick
//  tx_tick    out  1            1-cycle tx bit tick, every OVERSAMPLE rx_ticks
//  rx_sample  out  1            1-cycle mid-bit sample strobe for rx
//  rx_os_cnt  out  log2(OVERSAMPLE)  rx oversample phase
// BEHAVIOUR
//  Reset: cnt=0, acc=0, carry=0, tx_os=0, rx_os=0; div_a=RESET_DIV, frac_a=RESET_FRAC; all outputs 0.
//  Active divisor: eff = max(div_a, 2); interval period = eff + carry (carry in {0,1}).
//  Per enabled edge: if cnt==period-1 ("wrap"): cnt<=0, rx_tick<=1, {carry,acc}<=acc+frac_a;
//    else cnt<=cnt+1, rx_tick<=0. Carry produced at a wrap lengthens the NEXT interval.
//  All outputs registered; rx_tick/tx_tick/rx_sample high exactly one cycle per event.
//  First rx_tick is high after enabled edge number eff (counted from reset release).
//  tx: on wrap, tx_os<=tx_os+1 mod OVERSAMPLE; tx_tick<=1 iff tx_os==OVERSAMPLE-1 before increment.
//  rx: on wrap, rx_os<=rx_os+1 mod OVERSAMPLE; rx_sample<=1 iff rx_os==OVERSAMPLE/2-1 before increment.
//  rx_resync: rx_os<=0 next edge; does not touch cnt/acc/tx_os. Coincident with wrap: resync wins,
//    rx_os<=0, no rx_sample that cycle, rx_tick/tx_tick still issued.
//  div_load (priority over rx_resync and wrap): div_a/frac_a latched; cnt,acc,carry,tx_os,rx_os<=0;
//    all tick outputs 0 next cycle. Honoured even when en=0.
//  en=0: all counters hold, tick outputs 0; resume continues from held phase, no lost/extra tick.
//  div_int 0 or 1 clamped to 2 (max rx_tick rate clk/2). frac_a=0 gives exact integer division.
//  Widths: cnt DIV_WIDTH+1 bits so eff+1 never overflows; acc FRAC_WIDTH bits wraps naturally.
//  Long-run tx bit period = OVERSAMPLE*(eff + frac_a/2^FRAC_WIDTH) cycles, error <1 cycle per bit.
//  rst asserted mid-operation: immediate return to reset state, divisor back to RESET_DIV/FRAC.
// TESTING
//  Reset defaults, en=1: first rx_tick after edge 325; intervals 325,325,326,325,326...;
//    first tx_tick after edge 5207, next tx_tick 5208 cycles later, then steady 5208.
//  div_load div_int=4 frac=0: rx_tick every 4 cycles, tx_tick every 64, rx_sample on 8th rx_tick.
//  div_load div_int=1 (and 0): rx_tick every 2 cycles, no back-to-back ticks.
//  div_load mid-interval (cnt~100): outputs 0 next cycle, next rx_tick exactly eff cycles later.
//  rx_resync at arbitrary phase, div=4: rx_sample on 8th subsequent rx_tick; tx_tick timing unchanged;
//    resync on a wrap edge -> no rx_sample that cycle.
//  en low 50 cycles mid-interval: no ticks, rx_os_cnt frozen; resume -> remaining count completes.
//  rst pulse mid-run after div_load 4: counting restarts with 325 period.

Source files
------------

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: fractional clock divider producing an oversample tick,
// a tx bit tick every OVERSAMPLE oversample ticks, and a re-phasable rx mid-bit strobe.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned RESET_DIV  = 325,
  parameter int unsigned RESET_FRAC = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_WIDTH-1:0]          div_int,
  input  logic [FRAC_WIDTH-1:0]         div_frac,
  input  logic                          div_load,
  input  logic                          rx_resync,
  output logic                          rx_tick,
  output logic                          tx_tick,
  output logic                          rx_sample,
  output logic [$clog2(OVERSAMPLE)-1:0] rx_os_cnt
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W = DIV_WIDTH + 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [FRAC_WIDTH-1:0] frac_q, frac_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic [OS_W-1:0]       tx_os_q, tx_os_d;
  logic [OS_W-1:0]       rx_os_q, rx_os_d;
  logic                  rx_tick_q, rx_tick_d;
  logic                  tx_tick_q, tx_tick_d;
  logic                  rx_sample_q, rx_sample_d;

  logic [CNT_W-1:0]      eff;
  logic [CNT_W-1:0]      period_m1;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  wrap;

  // Divisors below 2 are clamped so ticks can never be back-to-back.
  assign eff       = (div_q < DIV_WIDTH'(2)) ? CNT_W'(2) : {1'b0, div_q};
  assign period_m1 = carry_q ? eff : eff - 1'b1;
  assign wrap      = (cnt_q == period_m1);
  assign acc_sum   = {1'b0, acc_q} + {1'b0, frac_q};

  always_comb begin
    div_d       = div_q;
    frac_d      = frac_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    tx_os_d     = tx_os_q;
    rx_os_d     = rx_os_q;
    rx_tick_d   = 1'b0;
    tx_tick_d   = 1'b0;
    rx_sample_d = 1'b0;
    if (div_load) begin
      div_d   = div_int;
      frac_d  = div_frac;
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      tx_os_d = '0;
      rx_os_d = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d              = '0;
        {carry_d, acc_d}   = acc_sum;
        rx_tick_d          = 1'b1;
        tx_os_d            = tx_os_q + 1'b1;
        tx_tick_d          = (tx_os_q == OS_LAST);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // A resync coinciding with a wrap swallows that wrap's rx phase step.
      if (rx_resync) begin
        rx_os_d = '0;
      end else if (wrap) begin
        rx_os_d     = rx_os_q + 1'b1;
        rx_sample_d = (rx_os_q == OS_MID);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= DIV_WIDTH'(RESET_DIV);
      frac_q      <= FRAC_WIDTH'(RESET_FRAC);
      cnt_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      tx_os_q     <= '0;
      rx_os_q     <= '0;
      rx_tick_q   <= 1'b0;
      tx_tick_q   <= 1'b0;
      rx_sample_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      tx_os_q     <= tx_os_d;
      rx_os_q     <= rx_os_d;
      rx_tick_q   <= rx_tick_d;
      tx_tick_q   <= tx_tick_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  assign rx_tick   = rx_tick_q;
  assign tx_tick   = tx_tick_q;
  assign rx_sample = rx_sample_q;
  assign rx_os_cnt = rx_os_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: closed-form tick-time model checked every cycle,
// plus directed scenarios with hand-computed tick spacings.
module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        rx_resync = 1'b0;
  logic        rx_tick;
  logic        tx_tick;
  logic        rx_sample;
  logic [3:0]  rx_os_cnt;

  int n_vec = 0;
  int n_err = 0;

  uart_baud_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_load  (div_load),
    .rx_resync (rx_resync),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick),
    .rx_sample (rx_sample),
    .rx_os_cnt (rx_os_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k-th tick of a phase lands on enabled edge k*eff + floor((k-1)*frac/16).
  longint m_div, m_frac, m_t, m_k, m_rxk;
  logic   e_rx_tick, e_tx_tick, e_rx_sample;
  longint e_os;

  function automatic longint tick_time(input longint k, input longint d, input longint f);
    longint eff;
    eff = (d < 2) ? 2 : d;
    return k * eff + (((k - 1) * f) / 16);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div = 325; m_frac = 8; m_t = 0; m_k = 0; m_rxk = 0;
      e_rx_tick = 0; e_tx_tick = 0; e_rx_sample = 0; e_os = 0;
    end else if (div_load) begin
      m_div = div_int; m_frac = div_frac; m_t = 0; m_k = 0; m_rxk = 0;
      e_rx_tick = 0; e_tx_tick = 0; e_rx_sample = 0; e_os = 0;
    end else if (en) begin
      logic tick;
      m_t++;
      tick = (m_t == tick_time(m_k + 1, m_div, m_frac));
      if (tick) m_k++;
      e_rx_tick = tick;
      e_tx_tick = tick && (m_k % 16 == 0);
      e_rx_sample = 0;
      if (rx_resync) begin
        m_rxk = 0;
      end else if (tick) begin
        m_rxk++;
        e_rx_sample = (m_rxk % 16 == 8);
      end
      e_os = m_rxk % 16;
    end else begin
      e_rx_tick = 0; e_tx_tick = 0; e_rx_sample = 0;
    end
  end

  always @(negedge clk) begin
    check("rx_tick", rx_tick, e_rx_tick);
    check("tx_tick", tx_tick, e_tx_tick);
    check("rx_sample", rx_sample, e_rx_sample);
    check("rx_os_cnt", rx_os_cnt, e_os);
  end

  // Counts falling edges until the selected output is seen high; -1 on timeout.
  task automatic wait_evt(input int sel, input int max, output int n);
    logic hit;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? rx_tick : (sel == 1) ? tx_tick : rx_sample;
      if (hit) break;
      if (n >= max) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic expect_gap(input string name, input int sel, input int exp);
    int n;
    wait_evt(sel, exp + 20, n);
    check(name, n, exp);
  endtask

  task automatic do_load(input int d, input int f);
    @(negedge clk);
    div_int = 16'(d);
    div_frac = 4'(f);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    check("load_clears_ticks", {rx_tick, tx_tick, rx_sample}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_tick", rx_tick, 0);
    check("rst_rx_os", rx_os_cnt, 0);

    // Reset defaults: 325 + 0.5 cycles per oversample tick.
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    expect_gap("def_first_rx", 0, 325);
    expect_gap("def_int2", 0, 325);
    expect_gap("def_int3", 0, 326);
    expect_gap("def_int4", 0, 325);
    expect_gap("def_int5", 0, 326);
    expect_gap("def_first_tx", 1, 5207 - 1627);
    expect_gap("def_tx2", 1, 5208);
    expect_gap("def_tx3", 1, 5208);

    // Integer divide by 4.
    do_load(4, 0);
    expect_gap("d4_rx1", 0, 4);
    expect_gap("d4_rx2", 0, 4);
    expect_gap("d4_sample", 2, 24);
    expect_gap("d4_tx1", 1, 32);
    expect_gap("d4_tx2", 1, 64);

    // Clamped divisors.
    do_load(1, 0);
    expect_gap("d1_rx1", 0, 2);
    expect_gap("d1_rx2", 0, 2);
    do_load(0, 0);
    expect_gap("d0_rx1", 0, 2);
    expect_gap("d0_rx2", 0, 2);

    // Reload mid-interval restarts the phase.
    do_load(200, 0);
    repeat (100) @(negedge clk);
    do_load(200, 3);
    expect_gap("reload_rx", 0, 200);

    // rx resync at a non-wrap edge, then on a wrap edge.
    do_load(4, 0);
    repeat (10) @(negedge clk);
    rx_resync = 1'b1;
    @(negedge clk);
    rx_resync = 1'b0;
    expect_gap("resync_sample", 2, 29);
    expect_gap("resync_tx", 1, 24);
    repeat (3) @(negedge clk);
    rx_resync = 1'b1;
    @(negedge clk);
    rx_resync = 1'b0;
    check("wrap_resync_tick", rx_tick, 1);
    check("wrap_resync_nosample", rx_sample, 0);
    check("wrap_resync_os", rx_os_cnt, 0);
    expect_gap("wrap_resync_sample", 2, 32);

    // Enable freeze mid-interval.
    do_load(4, 0);
    repeat (22) @(negedge clk);
    en = 1'b0;
    repeat (50) @(negedge clk);
    check("frozen_os", rx_os_cnt, 5);
    check("frozen_tick", rx_tick, 0);
    en = 1'b1;
    expect_gap("resume_rx", 0, 2);

    // Asynchronous reset mid-run returns to the default divisor.
    do_load(4, 0);
    repeat (10) @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ticks", {rx_tick, tx_tick, rx_sample}, 0);
    check("rst_mid_os", rx_os_cnt, 0);
    rst = 1'b0;
    expect_gap("rst_mid_first_rx", 0, 325);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
